// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit bridging the execute stage to a variable-latency data memory
// Optional feature macro: LSU_TIMEOUT_EN (memory wait limit of TIMEOUT cycles in REQ and WAIT_R)
module lsu_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wen,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [31:0]       i_wdata,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_trap,
    output logic              o_timeout,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [3:0]        o_mem_mask,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              wen_q, wen_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              trap_q, trap_d;
    logic [31:0]       rdata_q, rdata_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              limit_hit;
`endif

    logic        misaligned;
    logic [4:0]  shamt;
    logic [31:0] rshift;
    logic [31:0] load_ext;
    logic        in_req;

    // Request legality from the live core inputs, checked at acceptance
    always_comb begin
        misaligned = 1'b0;
        case (i_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = i_addr[0];
            2'b10:   misaligned = |i_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Lane shift and sign/zero extension of the returned read word
    always_comb begin
        shamt    = {addr_q[1:0], 3'b000};
        rshift   = i_mem_rdata >> shamt;
        load_ext = i_mem_rdata;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, rshift[7:0]}   : {{24{rshift[7]}}, rshift[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, rshift[15:0]}  : {{16{rshift[15]}}, rshift[15:0]};
            default: load_ext = i_mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    assign limit_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    // Next-state and captured-request logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wen_d   = wen_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        trap_d  = trap_q;
        rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    addr_d  = i_addr;
                    size_d  = i_size;
                    wen_d   = i_wen;
                    uns_d   = i_unsigned;
                    wdata_d = i_wdata;
                    rdata_d = 32'h0;
                    trap_d  = misaligned;
                    state_d = misaligned ? RESP : REQ;
`ifdef LSU_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    state_d = wen_q ? RESP : WAIT_R;
`ifdef LSU_TIMEOUT_EN
                    cnt_d = '0;
                end else if (limit_hit) begin
                    state_d   = RESP;
                    trap_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            WAIT_R: begin
                if (i_mem_rvalid) begin
                    rdata_d = load_ext;
                    state_d = RESP;
`ifdef LSU_TIMEOUT_EN
                end else if (limit_hit) begin
                    state_d   = RESP;
                    trap_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers; reset aborts any access in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= 2'b00;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            trap_q  <= 1'b0;
            rdata_q <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wen_q   <= wen_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            trap_q  <= trap_d;
            rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Core and memory outputs; memory fields only driven while a request is open
    always_comb begin
        in_req      = (state_q == REQ);
        o_ready     = (state_q == IDLE);
        o_done      = (state_q == RESP);
        o_trap      = o_done & trap_q;
        o_rdata     = o_done ? rdata_q : 32'h0;
`ifdef LSU_TIMEOUT_EN
        o_timeout   = o_done & timeout_q;
`else
        o_timeout   = 1'b0;
`endif
        o_mem_valid = in_req;
        o_mem_ren   = in_req & ~wen_q;
        o_mem_wen   = in_req & wen_q;
        o_mem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        o_mem_mask  = 4'b0000;
        o_mem_wdata = 32'h0;
        if (in_req) begin
            case (size_q)
                2'b00:   o_mem_mask = 4'b0001 << addr_q[1:0];
                2'b01:   o_mem_mask = addr_q[1] ? 4'b1100 : 4'b0011;
                default: o_mem_mask = 4'b1111;
            endcase
            o_mem_wdata = wdata_q << shamt;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed table-driven bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

    localparam int TO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_addr;
    logic        i_wen;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_wdata;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_trap;
    logic        o_timeout;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [3:0]  o_mem_mask;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_addr(i_addr), .i_wen(i_wen), .i_size(i_size), .i_unsigned(i_unsigned),
        .i_wdata(i_wdata), .o_done(o_done), .o_rdata(o_rdata), .o_trap(o_trap),
        .o_timeout(o_timeout), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_mask(o_mem_mask), .o_mem_wdata(o_mem_wdata), .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] memw;
        int          rdy;      // REQ cycles with ready low before acceptance
        int          rvd;      // cycles from acceptance to rvalid; 0 = never
        logic        trap;
        logic        tmo;
        logic [31:0] rdata;
        logic [3:0]  mask;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic do_access(input vec_t v);
        int  req_n;
        int  acc_c;
        int  done_c;
        int  exp_c;
        int  exp_req;
        logic done_seen;
        req_n = 0; acc_c = -1; done_c = -1; done_seen = 1'b0;
        @(negedge i_clk);
        chk({v.name, " ready_idle"}, {31'h0, o_ready}, 32'h1);
        i_valid = 1'b1; i_addr = v.addr; i_wen = v.wen; i_size = v.size;
        i_unsigned = v.uns; i_wdata = v.wdata; i_mem_rdata = v.memw;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        for (int c = 1; c <= 60 && !done_seen; c++) begin
            @(negedge i_clk);
            i_mem_rvalid = (!v.wen && acc_c >= 0 && v.rvd > 0 && c == acc_c + v.rvd);
            if (o_mem_valid) begin
                req_n++;
                chk({v.name, " mem_addr"}, o_mem_addr, v.maddr);
                chk({v.name, " mem_mask"}, {28'h0, o_mem_mask}, {28'h0, v.mask});
                chk({v.name, " mem_ren"}, {31'h0, o_mem_ren}, {31'h0, ~v.wen});
                chk({v.name, " mem_wen"}, {31'h0, o_mem_wen}, {31'h0, v.wen});
                if (v.wen)
                    chk({v.name, " mem_wdata"}, o_mem_wdata & lane_bits(v.mask),
                        v.mwdata & lane_bits(v.mask));
                i_mem_ready = (req_n > v.rdy);
                if (i_mem_ready) acc_c = c;
            end else begin
                i_mem_ready = 1'b0;
            end
            if (o_done) begin
                done_seen = 1'b1;
                done_c    = c;
                chk({v.name, " rdata"}, o_rdata, v.rdata);
                chk({v.name, " trap"}, {31'h0, o_trap}, {31'h0, v.trap});
                chk({v.name, " timeout"}, {31'h0, o_timeout}, {31'h0, v.tmo});
            end
        end
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
        if (v.trap && !v.tmo) begin
            exp_c = 1; exp_req = 0;
        end else if (v.tmo) begin
            exp_c = 1 + v.rdy + 1 + TO; exp_req = v.rdy + 1;
        end else if (v.wen) begin
            exp_c = 1 + v.rdy + 1; exp_req = v.rdy + 1;
        end else begin
            exp_c = 1 + v.rdy + v.rvd + 1; exp_req = v.rdy + 1;
        end
        chk({v.name, " done_seen"}, {31'h0, done_seen}, 32'h1);
        chk({v.name, " latency"}, done_c, exp_c);
        chk({v.name, " req_cycles"}, req_n, exp_req);
        // One cycle after done: back in IDLE; a stray rvalid must be ignored
        @(negedge i_clk);
        chk({v.name, " single_done"}, {31'h0, o_done}, 32'h0);
        chk({v.name, " ready_after"}, {31'h0, o_ready}, 32'h1);
        i_mem_rvalid = 1'b1;
        @(negedge i_clk);
        i_mem_rvalid = 1'b0;
        chk({v.name, " stray_rvalid"}, {30'h0, o_done, o_mem_valid}, 32'h0);
    endtask

    initial begin
        vec_t v;
        //         name      addr          wen   size   uns   wdata          memw          rdy rvd trap  tmo   rdata          mask     maddr          mwdata
        tbl.push_back('{"lb",   32'h1003, 1'b0, 2'b00, 1'b0, 32'h0,        32'h80FF_1234, 0, 1, 1'b0, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0000_1000, 32'h0});
        tbl.push_back('{"lbu",  32'h1003, 1'b0, 2'b00, 1'b1, 32'h0,        32'h80FF_1234, 0, 1, 1'b0, 1'b0, 32'h0000_0080, 4'b1000, 32'h0000_1000, 32'h0});
        tbl.push_back('{"sh",   32'h2002, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0,         4'b1100, 32'h0000_2000, 32'hBEEF_0000});
        tbl.push_back('{"lw_mis", 32'h3001, 1'b0, 2'b10, 1'b0, 32'h0,      32'h1234_5678, 0, 1, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0});
        tbl.push_back('{"sh_mis", 32'h3003, 1'b1, 2'b01, 1'b0, 32'hFFFF,   32'h0,         0, 0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0});
        tbl.push_back('{"sz11", 32'h0020, 1'b0, 2'b11, 1'b0, 32'h0,        32'h1111_1111, 0, 1, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0});
        tbl.push_back('{"lh_hi", 32'h0002, 1'b0, 2'b01, 1'b0, 32'h0,       32'h8001_7FFF, 0, 1, 1'b0, 1'b0, 32'hFFFF_8001, 4'b1100, 32'h0000_0000, 32'h0});
        tbl.push_back('{"lhu_hi", 32'h0002, 1'b0, 2'b01, 1'b1, 32'h0,      32'h8001_7FFF, 0, 1, 1'b0, 1'b0, 32'h0000_8001, 4'b1100, 32'h0000_0000, 32'h0});
        tbl.push_back('{"lh_lo", 32'h0000, 1'b0, 2'b01, 1'b0, 32'h0,       32'h8001_7FFF, 0, 1, 1'b0, 1'b0, 32'h0000_7FFF, 4'b0011, 32'h0000_0000, 32'h0});
        tbl.push_back('{"sb",   32'h0005, 1'b1, 2'b00, 1'b0, 32'h1234_5678, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0,         4'b0010, 32'h0000_0004, 32'h0000_7800});
        tbl.push_back('{"sw",   32'h0010, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0,        2, 0, 1'b0, 1'b0, 32'h0,         4'b1111, 32'h0000_0010, 32'hDEAD_BEEF});
        tbl.push_back('{"lw_bp", 32'h0044, 1'b0, 2'b10, 1'b0, 32'h0,       32'hCAFE_F00D, 5, 4, 1'b0, 1'b0, 32'hCAFE_F00D, 4'b1111, 32'h0000_0044, 32'h0});
`ifdef LSU_TIMEOUT_EN
        tbl.push_back('{"lw_tmo", 32'h0050, 1'b0, 2'b10, 1'b0, 32'h0,      32'h5555_AAAA, 0, 0, 1'b1, 1'b1, 32'h0,         4'b1111, 32'h0000_0050, 32'h0});
`endif

        i_rst_n = 1'b0; i_valid = 1'b0; i_addr = 32'h0; i_wen = 1'b0; i_size = 2'b00;
        i_unsigned = 1'b0; i_wdata = 32'h0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
        i_mem_rdata = 32'h0;
        repeat (3) @(negedge i_clk);
        chk("rst ready", {31'h0, o_ready}, 32'h1);
        chk("rst outs", {26'h0, o_done, o_trap, o_timeout, o_mem_valid, o_mem_ren, o_mem_wen}, 32'h0);
        chk("rst data", o_rdata | o_mem_addr | o_mem_wdata | {28'h0, o_mem_mask}, 32'h0);
        i_rst_n = 1'b1;

        foreach (tbl[i]) do_access(tbl[i]);

        // Reset asserted while a load waits for read data
        @(negedge i_clk);
        i_valid = 1'b1; i_addr = 32'h100; i_wen = 1'b0; i_size = 2'b10; i_unsigned = 1'b0;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        chk("rstmid req", {31'h0, o_mem_valid}, 32'h1);
        i_mem_ready = 1'b1;
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        chk("rstmid wait", {30'h0, o_mem_valid, o_ready}, 32'h0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rstmid ready", {31'h0, o_ready}, 32'h1);
        chk("rstmid outs", {28'h0, o_done, o_trap, o_mem_valid, o_mem_ren}, 32'h0);
        chk("rstmid rdata", o_rdata, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_mem_rdata = 32'h9999_9999;
        i_mem_rvalid = 1'b1;
        @(negedge i_clk);
        i_mem_rvalid = 1'b0;
        chk("rstmid no_done1", {31'h0, o_done}, 32'h0);
        @(negedge i_clk);
        chk("rstmid no_done2", {30'h0, o_done, o_ready}, 32'h1);

        v = '{"lw0_after_rst", 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 0, 1,
              1'b0, 1'b0, 32'h1122_3344, 4'b1111, 32'h0, 32'h0};
        do_access(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
